// File: rtl/lcd_spi_tx_pkg.sv
// Shared types and frame-size helper for the LCD SPI write serializer.
// No logic; latency and backpressure are defined by the users of these types.
package lcd_spi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_STALL = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // 3-wire frames carry D/C in-band as one extra leading bit
    function automatic int frame_bits(input int word_width, input int three_wire);
        return word_width + ((three_wire != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/lcd_spi_tx_if.sv
// Upstream packet stream {dc, last, word} into the LCD SPI serializer.
// Plain valid/ready: a transfer happens on any cycle with in_valid & in_ready.
interface lcd_spi_tx_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_dc;
    logic                  in_last;

    modport master (output in_valid, output in_data, output in_dc, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dc, input in_last, output in_ready);
endinterface

// File: rtl/lcd_spi_tx_clkgen.sv
// Half-period divider producing registered sck plus strobes on the last cycle of each phase.
// Latency: strobes are combinational from the count; sck toggles on the clock after a strobe.
// Backpressure: none; the FSM runs it with en and forces sck low with sck_en=0.
module lcd_spi_tx_clkgen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sck_en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_TERM = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          term;

    assign term     = en && (div_cnt == DIV_TERM);
    assign rise_stb = term && !sck;
    assign fall_stb = term && sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            if (!en || term) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (!sck_en) begin
                sck <= 1'b0;
            end else if (term) begin
                sck <= !sck;
            end
        end
    end
endmodule

// File: rtl/lcd_spi_tx.sv
// SPI mode-0 write serializer for ST7789-class panels: {dc,last,word} packets to sck/sda/cs_n/dc.
// Latency: cs_n falls and the first bit appears the cycle after acceptance; frame = BITS*2*CLK_DIV cycles.
// Backpressure: in_ready only in IDLE, STALL and the final cycle of a non-last frame.
module lcd_spi_tx
    import lcd_spi_tx_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = 1,
    parameter int MSB_FIRST  = 1,
    parameter int THREE_WIRE = 0,
    parameter int CS_GAP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    lcd_spi_tx_if.slave        in_if,
    output logic               busy,
    output logic               sck,
    output logic               sda,
    output logic               cs_n,
    output logic               dc
);
    localparam int            BITS     = frame_bits(WORD_WIDTH, THREE_WIRE);
    localparam int            BW       = $clog2(BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);
    // The first IDLE cycle also has cs_n high, so GAP itself is one cycle shorter than CS_GAP
    localparam int            GAP_CYC  = CS_GAP - 1;
    localparam int            GW       = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_TERM = GW'(GAP_CYC - 1);

    state_t                state_q, state_d;
    logic                  armed;
    logic [BITS-1:0]       frame;
    logic [BITS-1:0]       shreg;
    logic [WORD_WIDTH-1:0] word_ord;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  last_q;
    logic                  xfer;
    logic                  frame_end;
    logic                  clk_en;
    logic                  sck_en;
    logic                  rise_stb;
    logic                  fall_stb;

    always_comb begin
        word_ord = in_if.in_data;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
                word_ord[i] = in_if.in_data[WORD_WIDTH-1-i];
            end
        end
    end

    generate
        if (THREE_WIRE != 0) begin : g_three_wire
            assign frame = {in_if.in_dc, word_ord};
        end else begin : g_four_wire
            assign frame = word_ord;
        end
    endgenerate

    assign clk_en    = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign sck_en    = (state_q == ST_SHIFT);
    assign frame_end = (state_q == ST_SHIFT) && fall_stb && (bit_cnt == LAST_BIT);

    assign in_if.in_ready = ((state_q == ST_IDLE) && armed) || (state_q == ST_STALL) ||
                            (frame_end && !last_q);
    assign xfer = in_if.in_valid && in_if.in_ready;
    assign busy = (state_q != ST_IDLE);

    lcd_spi_tx_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .en       (clk_en),
        .sck_en   (sck_en),
        .sck      (sck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (frame_end) begin
                    if (xfer)        state_d = ST_SHIFT;
                    else if (last_q) state_d = ST_HOLD;
                    else             state_d = ST_STALL;
                end
            end
            ST_STALL: if (xfer) state_d = ST_SHIFT;
            ST_HOLD:  if (rise_stb) state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == GAP_TERM) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            armed   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            last_q  <= 1'b0;
            sda     <= 1'b0;
            cs_n    <= 1'b1;
            dc      <= 1'b0;
        end else begin
            state_q <= state_d;
            armed   <= 1'b1;
            cs_n    <= !(state_d inside {ST_SHIFT, ST_STALL, ST_HOLD});
            if (xfer) begin
                shreg   <= frame << 1;
                sda     <= frame[BITS-1];
                bit_cnt <= '0;
                last_q  <= in_if.in_last;
                dc      <= (THREE_WIRE != 0) ? 1'b0 : in_if.in_dc;
            end else if ((state_q == ST_SHIFT) && fall_stb && !frame_end) begin
                sda     <= shreg[BITS-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_d == ST_IDLE) begin
                dc <= 1'b0;
            end
            gap_cnt <= (state_q == ST_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: three instances (default, 3-wire LSB-first, CLK_DIV=3)
// observed through one selectable sck/sda/dc/cs_n edge recorder.
module tb_lcd_spi_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sck_w, sda_w, cs_w, dc_w, busy_w;
    logic [1:0] sel = 2'd0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    lcd_spi_tx_if #(.WORD_WIDTH(8)) if0 ();
    lcd_spi_tx_if #(.WORD_WIDTH(8)) if1 ();
    lcd_spi_tx_if #(.WORD_WIDTH(8)) if2 ();

    lcd_spi_tx #(.WORD_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1), .THREE_WIRE(0), .CS_GAP(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_if(if0.slave), .busy(busy_w[0]),
        .sck(sck_w[0]), .sda(sda_w[0]), .cs_n(cs_w[0]), .dc(dc_w[0]));
    lcd_spi_tx #(.WORD_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0), .THREE_WIRE(1), .CS_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_if(if1.slave), .busy(busy_w[1]),
        .sck(sck_w[1]), .sda(sda_w[1]), .cs_n(cs_w[1]), .dc(dc_w[1]));
    lcd_spi_tx #(.WORD_WIDTH(8), .CLK_DIV(3), .MSB_FIRST(1), .THREE_WIRE(0), .CS_GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_if(if2.slave), .busy(busy_w[2]),
        .sck(sck_w[2]), .sda(sda_w[2]), .cs_n(cs_w[2]), .dc(dc_w[2]));

    // Edge recorder for the selected instance, sampled on the falling clk edge
    logic m_sck, m_sda, m_cs, m_dc;
    logic m_sck_p = 1'b0;
    logic m_cs_p  = 1'b1;
    int   cyc = 0, hi_cnt = 0, cs_cnt = 0;
    int   rise_t[$], hi_len[$], csh_len[$], csf_t[$];
    bit   rise_sda[$], rise_dc[$], rise_cs[$];

    assign m_sck = sck_w[sel];
    assign m_sda = sda_w[sel];
    assign m_cs  = cs_w[sel];
    assign m_dc  = dc_w[sel];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_sck && !m_sck_p) begin
            rise_t.push_back(cyc);
            rise_sda.push_back(m_sda);
            rise_dc.push_back(m_dc);
            rise_cs.push_back(m_cs);
        end
        if (m_sck) hi_cnt <= hi_cnt + 1;
        else begin
            if (m_sck_p) hi_len.push_back(hi_cnt);
            hi_cnt <= 0;
        end
        if (m_cs) cs_cnt <= cs_cnt + 1;
        else begin
            if (m_cs_p) begin
                csh_len.push_back(cs_cnt);
                csf_t.push_back(cyc);
            end
            cs_cnt <= 0;
        end
        m_sck_p <= m_sck;
        m_cs_p  <= m_cs;
    end

    task automatic mon_clear();
        rise_t.delete(); rise_sda.delete(); rise_dc.delete(); rise_cs.delete();
        hi_len.delete(); csh_len.delete(); csf_t.delete();
    endtask

    // what: 0 = sda, 1 = dc, 2 = cs_n, each sampled at sck rising edges
    function automatic logic [31:0] pack(input int first, input int n, input int what);
        logic [31:0] v;
        bit          b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (first + i < rise_t.size()) begin
                case (what)
                    0:       b = rise_sda[first+i];
                    1:       b = rise_dc[first+i];
                    default: b = rise_cs[first+i];
                endcase
            end
            v = {v[30:0], b};
        end
        return v;
    endfunction

    function automatic logic rdy(input int k);
        case (k)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    task automatic set_src(input int k, input logic v, input logic [7:0] w, input logic d, input logic l);
        case (k)
            0: begin if0.in_valid = v; if0.in_data = w; if0.in_dc = d; if0.in_last = l; end
            1: begin if1.in_valid = v; if1.in_data = w; if1.in_dc = d; if1.in_last = l; end
            default: begin if2.in_valid = v; if2.in_data = w; if2.in_dc = d; if2.in_last = l; end
        endcase
    endtask

    // Returns #1 after the clk edge on which the packet was accepted
    task automatic push(input int k, input logic [7:0] w, input logic d, input logic l);
        int n = 0;
        set_src(k, 1'b1, w, d, l);
        while (rdy(k) !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= 500) $display("FAIL push_timeout dut%0d word %h: in_ready never 1 within 500 cycles", k, w);
        else n_pass++;
        @(posedge clk); #1;
        set_src(k, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (busy_w[k] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= budget) $display("FAIL idle_timeout dut%0d: busy still %b after %0d cycles, required 0", k, busy_w[k], budget);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_chk++;
        if ({cs_w[0], sck_w[0], sda_w[0], dc_w[0], busy_w[0], if0.in_ready} !== 6'b100000)
            $display("FAIL reset_dut0 {cs_n,sck,sda,dc,busy,ready}=%b required 100000",
                     {cs_w[0], sck_w[0], sda_w[0], dc_w[0], busy_w[0], if0.in_ready});
        else n_pass++;
        n_chk++;
        if ({cs_w[2], sck_w[2], sda_w[2], dc_w[2], busy_w[2], if2.in_ready} !== 6'b100000)
            $display("FAIL reset_dut2 {cs_n,sck,sda,dc,busy,ready}=%b required 100000",
                     {cs_w[2], sck_w[2], sda_w[2], dc_w[2], busy_w[2], if2.in_ready});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (if0.in_ready !== 1'b0) $display("FAIL ready_before_edge actual %b required 0", if0.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (if0.in_ready !== 1'b1) $display("FAIL ready_after_edge actual %b required 1", if0.in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        sel = 2'd0;
        repeat (2) @(posedge clk); #1;
        mon_clear();
        push(0, 8'h2A, 1'b0, 1'b1);
        wait_idle(0, 200);
        n_chk++;
        if (rise_t.size() !== 8) $display("FAIL single_bits count %0d required 8", rise_t.size());
        else n_pass++;
        n_chk++;
        if (pack(0, 8, 0) !== 32'h2A) $display("FAIL single_sda actual %h required 2a", pack(0, 8, 0));
        else n_pass++;
        n_chk++;
        if (pack(0, 8, 1) !== 32'h00 || pack(0, 8, 2) !== 32'h00)
            $display("FAIL single_dc_cs dc %h cs_n %h required 00 00", pack(0, 8, 1), pack(0, 8, 2));
        else n_pass++;
        n_chk++;
        if (rise_t[0] - csf_t[0] !== 1) $display("FAIL single_first_rise delay %0d required 1", rise_t[0] - csf_t[0]);
        else n_pass++;
        n_chk++;
        if (cs_w[0] !== 1'b1 || dc_w[0] !== 1'b0) $display("FAIL single_idle cs_n %b dc %b required 1 0", cs_w[0], dc_w[0]);
        else n_pass++;
    endtask

    task automatic test_burst();
        int odd = 0;
        mon_clear();
        push(0, 8'h2C, 1'b0, 1'b0);
        push(0, 8'h12, 1'b1, 1'b0);
        push(0, 8'h34, 1'b1, 1'b1);
        wait_idle(0, 300);
        for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != 2) odd++;
        n_chk++;
        if (rise_t.size() !== 24 || odd !== 0)
            $display("FAIL burst_timing rises %0d irregular %0d required 24 0", rise_t.size(), odd);
        else n_pass++;
        n_chk++;
        if (pack(0, 24, 0) !== 32'h2C1234) $display("FAIL burst_sda actual %h required 2c1234", pack(0, 24, 0));
        else n_pass++;
        n_chk++;
        if (pack(0, 24, 1) !== 32'h00FFFF) $display("FAIL burst_dc actual %h required 00ffff", pack(0, 24, 1));
        else n_pass++;
        n_chk++;
        if (pack(0, 24, 2) !== 32'h0 || csh_len.size() !== 1)
            $display("FAIL burst_cs cs_n %h falls %0d required 0 1", pack(0, 24, 2), csh_len.size());
        else n_pass++;
    endtask

    task automatic test_stall();
        int odd = 0, odd_val = 0, bad_hi = 0;
        mon_clear();
        push(0, 8'h2C, 1'b0, 1'b0);
        push(0, 8'h12, 1'b1, 1'b0);
        repeat (18) @(posedge clk); #1;
        n_chk++;
        if ({if0.in_ready, sck_w[0], cs_w[0], busy_w[0]} !== 4'b1001)
            $display("FAIL stall_state {ready,sck,cs_n,busy}=%b required 1001",
                     {if0.in_ready, sck_w[0], cs_w[0], busy_w[0]});
        else n_pass++;
        repeat (3) @(posedge clk); #1;
        push(0, 8'h34, 1'b1, 1'b1);
        wait_idle(0, 300);
        for (int i = 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i-1] != 2) begin
                odd++;
                odd_val = rise_t[i] - rise_t[i-1];
            end
        end
        foreach (hi_len[i]) if (hi_len[i] != 1) bad_hi++;
        n_chk++;
        if (odd !== 1 || odd_val !== 8)
            $display("FAIL stall_spacing irregular %0d gap %0d required 1 8", odd, odd_val);
        else n_pass++;
        n_chk++;
        if (pack(0, 24, 0) !== 32'h2C1234 || pack(0, 24, 1) !== 32'h00FFFF)
            $display("FAIL stall_data sda %h dc %h required 2c1234 00ffff", pack(0, 24, 0), pack(0, 24, 1));
        else n_pass++;
        n_chk++;
        if (hi_len.size() !== 24 || bad_hi !== 0 || csh_len.size() !== 1)
            $display("FAIL stall_glitch highs %0d bad %0d cs_falls %0d required 24 0 1",
                     hi_len.size(), bad_hi, csh_len.size());
        else n_pass++;
    endtask

    task automatic test_three_wire();
        sel = 2'd1;
        repeat (2) @(posedge clk); #1;
        mon_clear();
        push(1, 8'h01, 1'b1, 1'b1);
        wait_idle(1, 200);
        n_chk++;
        if (rise_t.size() !== 9) $display("FAIL tw_bits count %0d required 9", rise_t.size());
        else n_pass++;
        n_chk++;
        if (pack(0, 9, 0) !== 32'h180) $display("FAIL tw_sda actual %h required 180", pack(0, 9, 0));
        else n_pass++;
        n_chk++;
        if (pack(0, 9, 1) !== 32'h0) $display("FAIL tw_dc_pin actual %h required 0", pack(0, 9, 1));
        else n_pass++;
    endtask

    task automatic test_clkdiv();
        int bad_hi = 0;
        sel = 2'd2;
        repeat (2) @(posedge clk); #1;
        mon_clear();
        push(2, 8'hA5, 1'b1, 1'b1);
        push(2, 8'h3C, 1'b0, 1'b1);
        wait_idle(2, 400);
        foreach (hi_len[i]) if (hi_len[i] != 3) bad_hi++;
        n_chk++;
        if (hi_len.size() !== 16 || bad_hi !== 0)
            $display("FAIL div_high highs %0d bad %0d required 16 0", hi_len.size(), bad_hi);
        else n_pass++;
        n_chk++;
        if (rise_t[0] - csf_t[0] !== 3 || rise_t[7] - rise_t[0] !== 42)
            $display("FAIL div_timing first %0d span %0d required 3 42", rise_t[0] - csf_t[0], rise_t[7] - rise_t[0]);
        else n_pass++;
        n_chk++;
        if (pack(0, 16, 0) !== 32'hA53C || pack(0, 16, 1) !== 32'hFF00)
            $display("FAIL div_data sda %h dc %h required a53c ff00", pack(0, 16, 0), pack(0, 16, 1));
        else n_pass++;
        n_chk++;
        if (csh_len.size() !== 2 || csh_len[1] !== 2)
            $display("FAIL div_cs_gap falls %0d gap %0d required 2 2", csh_len.size(), csh_len[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        sel = 2'd0;
        repeat (2) @(posedge clk); #1;
        mon_clear();
        push(0, 8'hFF, 1'b1, 1'b1);
        while (rise_t.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= 100) $display("FAIL mid_wait rises %0d required 4", rise_t.size());
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({cs_w[0], sck_w[0], sda_w[0], dc_w[0], busy_w[0], if0.in_ready} !== 6'b100000)
            $display("FAIL mid_reset {cs_n,sck,sda,dc,busy,ready}=%b required 100000",
                     {cs_w[0], sck_w[0], sda_w[0], dc_w[0], busy_w[0], if0.in_ready});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        mon_clear();
        push(0, 8'h5A, 1'b1, 1'b1);
        wait_idle(0, 200);
        n_chk++;
        if (rise_t.size() !== 8 || pack(0, 8, 0) !== 32'h5A || pack(0, 8, 1) !== 32'hFF)
            $display("FAIL mid_fresh rises %0d sda %h dc %h required 8 5a ff",
                     rise_t.size(), pack(0, 8, 0), pack(0, 8, 1));
        else n_pass++;
    endtask

    initial begin
        set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
        set_src(2, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_three_wire();
        test_clkdiv();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
